// File: rtl/conv_pkg.sv
// Shared definitions for the window shift bank.
// Holds the shift-mode encoding and small decode helpers.
package conv_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD     = 3'd0,
        MODE_UP       = 3'd1,
        MODE_DOWN     = 3'd2,
        MODE_CENTER   = 3'd3,
        MODE_ROT_UP   = 3'd4,
        MODE_ROT_DOWN = 3'd5
    } mode_e;

    function automatic logic is_legal_mode(input logic [2:0] code);
        return (code <= 3'd5);
    endfunction

    // Number of new samples an operation pushes into the window.
    function automatic logic [1:0] fill_incr(input logic [2:0] code);
        logic [1:0] incr;
        case (code)
            3'd1:    incr = 2'd1;
            3'd2:    incr = 2'd1;
            3'd3:    incr = 2'd2;
            default: incr = 2'd0;
        endcase
        return incr;
    endfunction

endpackage

// File: rtl/win_shift_lane.sv
// One channel of the window: N registered taps of B bits with the shift muxing.
// Enable and op come from the shared control path in the top.
module win_shift_lane
    import conv_pkg::*;
#(
    parameter int N = 11,
    parameter int B = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                en,
    input  mode_e               op,
    input  logic [B-1:0]        din,
    output logic [N-1:0][B-1:0] taps
);

    localparam int N2 = (N + 1) / 2;

    logic [N-1:0][B-1:0] tap_q;
    logic [N-1:0][B-1:0] tap_d;
    logic [N-1:0][B-1:0] center_s;

    // CENTER: both ends take din, each half moves inward; the two middle taps drop out.
    assign center_s[0]   = din;
    assign center_s[N-1] = din;
    for (genvar i = 1; i < N - 1; i++) begin : g_center
        if (i < N2) begin : g_low
            assign center_s[i] = tap_q[i-1];
        end else begin : g_high
            assign center_s[i] = tap_q[i+1];
        end
    end

    // Next-state tap selection.
    always_comb begin
        tap_d = tap_q;
        if (en) begin
            case (op)
                MODE_UP:       tap_d = {tap_q[N-2:0], din};
                MODE_DOWN:     tap_d = {din, tap_q[N-1:1]};
                MODE_CENTER:   tap_d = center_s;
                MODE_ROT_UP:   tap_d = {tap_q[N-2:0], tap_q[N-1]};
                MODE_ROT_DOWN: tap_d = {tap_q[0], tap_q[N-1:1]};
                default:       tap_d = tap_q;
            endcase
        end else begin
            tap_d = tap_q;
        end
    end

    // Tap registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tap_q <= '0;
        end else if (flush) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end

    assign taps = tap_q;

endmodule

// File: rtl/window_shift_bank.sv
// Multi-channel sliding window: C lanes share one mode/valid control path,
// plus a single fill counter, window-valid flag and sticky illegal-mode flag.
module window_shift_bank
    import conv_pkg::*;
#(
    parameter int N = 11,
    parameter int B = 8,
    parameter int C = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [2:0]                   mode,
    input  logic [C-1:0][B-1:0]          din,
    output logic [C-1:0][N-1:0][B-1:0]   dout,
    output logic [$clog2(N+1)-1:0]       fill,
    output logic                         win_valid,
    output logic                         mode_err
);

    localparam int FW = $clog2(N + 1);

    mode_e         op_s;
    logic          legal_s;
    logic          lane_en_s;
    logic [FW:0]   fill_sum_s;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic          win_valid_q;
    logic          win_valid_d;
    logic          mode_err_q;
    logic          mode_err_d;

    assign op_s       = mode_e'(mode);
    assign legal_s    = is_legal_mode(mode);
    assign lane_en_s  = in_valid & legal_s;
    assign fill_sum_s = {1'b0, fill_q} + (FW + 1)'(fill_incr(mode));

    for (genvar c = 0; c < C; c++) begin : g_lane
        win_shift_lane #(
            .N (N),
            .B (B)
        ) u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .flush (flush),
            .en    (lane_en_s),
            .op    (op_s),
            .din   (din[c]),
            .taps  (dout[c])
        );
    end

    // Saturating fill count and sticky error; win_valid is registered from next fill.
    always_comb begin
        fill_d     = fill_q;
        mode_err_d = mode_err_q;
        if (in_valid) begin
            if (legal_s) begin
                if (fill_sum_s >= (FW + 1)'(N)) begin
                    fill_d = FW'(N);
                end else begin
                    fill_d = fill_sum_s[FW-1:0];
                end
            end else begin
                mode_err_d = 1'b1;
            end
        end else begin
            fill_d     = fill_q;
            mode_err_d = mode_err_q;
        end
        win_valid_d = (fill_d == FW'(N));
    end

    // Shared control registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fill_q      <= '0;
            win_valid_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else if (flush) begin
            fill_q      <= '0;
            win_valid_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            win_valid_q <= win_valid_d;
            mode_err_q  <= mode_err_d;
        end
    end

    assign fill      = fill_q;
    assign win_valid = win_valid_q;
    assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_window_shift_bank.sv
// Scoreboard bench for window_shift_bank (N=5, B=8, C=2) with directed vectors.
module tb_window_shift_bank;

    localparam int N = 5;
    localparam int B = 8;
    localparam int C = 2;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_UP   = 3'd1;
    localparam logic [2:0] M_DOWN = 3'd2;
    localparam logic [2:0] M_CTR  = 3'd3;
    localparam logic [2:0] M_RUP  = 3'd4;
    localparam logic [2:0] M_RDN  = 3'd5;
    localparam logic [2:0] M_BAD6 = 3'd6;
    localparam logic [39:0] Z     = 40'h0;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic                       flush = 1'b0;
    logic                       in_valid = 1'b0;
    logic [2:0]                 mode = 3'd0;
    logic [C-1:0][B-1:0]        din = '0;
    logic [C-1:0][N-1:0][B-1:0] dout;
    logic [2:0]                 fill;
    logic                       win_valid;
    logic                       mode_err;

    typedef struct {
        int          id;
        int          due;
        logic [79:0] dout;
        logic [2:0]  fill;
        logic        wv;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_step = 0;
    int   checks = 0;
    int   failures = 0;

    window_shift_bank #(.N(N), .B(B), .C(C)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .mode      (mode),
        .din       (din),
        .dout      (dout),
        .fill      (fill),
        .win_valid (win_valid),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each expectation once its sampling edge has passed.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 4;
            if (dout !== e.dout) begin
                failures = failures + 1;
                $display("FAIL dout step=%0d got=%h exp=%h", e.id, dout, e.dout);
            end
            if (fill !== e.fill) begin
                failures = failures + 1;
                $display("FAIL fill step=%0d got=%0d exp=%0d", e.id, fill, e.fill);
            end
            if (win_valid !== e.wv) begin
                failures = failures + 1;
                $display("FAIL win_valid step=%0d got=%b exp=%b", e.id, win_valid, e.wv);
            end
            if (mode_err !== e.err) begin
                failures = failures + 1;
                $display("FAIL mode_err step=%0d got=%b exp=%b", e.id, mode_err, e.err);
            end
        end
    end

    // e0/e1: expected taps of channel 0/1 packed as {tap4,tap3,tap2,tap1,tap0}.
    task automatic step(input logic r, input logic f, input logic v, input logic [2:0] m,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [39:0] e0, input logic [39:0] e1,
                        input logic [2:0] ef, input logic ew, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rstn     = r;
        flush    = f;
        in_valid = v;
        mode     = m;
        din[0]   = a;
        din[1]   = b;
        n_step   = n_step + 1;
        e.id   = n_step;
        e.due  = cyc + 1;
        e.dout = {e1, e0};
        e.fill = ef;
        e.wv   = ew;
        e.err  = ee;
        exp_q.push_back(e);
    endtask

    initial begin
        // reset
        step(0, 0, 0, M_HOLD, 8'h00, 8'h00, Z, Z, 3'd0, 0, 0);
        // five UP ops
        step(1, 0, 1, M_UP, 8'h01, 8'h11, 40'h0000000001, 40'h0000000011, 3'd1, 0, 0);
        step(1, 0, 1, M_UP, 8'h02, 8'h12, 40'h0000000102, 40'h0000001112, 3'd2, 0, 0);
        step(1, 0, 1, M_UP, 8'h03, 8'h13, 40'h0000010203, 40'h0000111213, 3'd3, 0, 0);
        step(1, 0, 1, M_UP, 8'h04, 8'h14, 40'h0001020304, 40'h0011121314, 3'd4, 0, 0);
        step(1, 0, 1, M_UP, 8'h05, 8'h15, 40'h0102030405, 40'h1112131415, 3'd5, 1, 0);
        // rotations, din ignored
        step(1, 0, 1, M_RUP, 8'hFF, 8'hEE, 40'h0203040501, 40'h1213141511, 3'd5, 1, 0);
        step(1, 0, 1, M_RDN, 8'hFF, 8'hEE, 40'h0102030405, 40'h1112131415, 3'd5, 1, 0);
        // in_valid low holds
        step(1, 0, 0, M_UP, 8'h99, 8'h98, 40'h0102030405, 40'h1112131415, 3'd5, 1, 0);
        // saturated UP and DOWN
        step(1, 0, 1, M_UP, 8'h06, 8'h16, 40'h0203040506, 40'h1213141516, 3'd5, 1, 0);
        step(1, 0, 1, M_DOWN, 8'h07, 8'h17, 40'h0702030405, 40'h1712131415, 3'd5, 1, 0);
        // flush overrides UP
        step(1, 1, 1, M_UP, 8'h08, 8'h18, Z, Z, 3'd0, 0, 0);
        // CENTER from empty
        step(1, 0, 1, M_CTR, 8'hA0, 8'hB0, 40'hA0000000A0, 40'hB0000000B0, 3'd2, 0, 0);
        step(1, 0, 1, M_CTR, 8'hA1, 8'hB1, 40'hA1A000A0A1, 40'hB1B000B0B1, 3'd4, 0, 0);
        step(1, 0, 1, M_CTR, 8'hA2, 8'hB2, 40'hA2A1A0A1A2, 40'hB2B1B0B1B2, 3'd5, 1, 0);
        step(1, 1, 0, M_HOLD, 8'h00, 8'h00, Z, Z, 3'd0, 0, 0);
        // fill to 3, then illegal mode
        step(1, 0, 1, M_UP, 8'h01, 8'h21, 40'h0000000001, 40'h0000000021, 3'd1, 0, 0);
        step(1, 0, 1, M_UP, 8'h02, 8'h22, 40'h0000000102, 40'h0000002122, 3'd2, 0, 0);
        step(1, 0, 1, M_UP, 8'h03, 8'h23, 40'h0000010203, 40'h0000212223, 3'd3, 0, 0);
        step(1, 0, 1, M_BAD6, 8'h77, 8'h78, 40'h0000010203, 40'h0000212223, 3'd3, 0, 1);
        step(1, 0, 1, M_HOLD, 8'h77, 8'h78, 40'h0000010203, 40'h0000212223, 3'd3, 0, 1);
        // ten UP ops, error stays sticky
        step(1, 0, 1, M_UP, 8'h55, 8'h66, 40'h0001020355, 40'h0021222366, 3'd4, 0, 1);
        step(1, 0, 1, M_UP, 8'h55, 8'h66, 40'h0102035555, 40'h2122236666, 3'd5, 1, 1);
        step(1, 0, 1, M_UP, 8'h55, 8'h66, 40'h0203555555, 40'h2223666666, 3'd5, 1, 1);
        step(1, 0, 1, M_UP, 8'h55, 8'h66, 40'h0355555555, 40'h2366666666, 3'd5, 1, 1);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 1, M_UP, 8'h55, 8'h66, 40'h5555555555, 40'h6666666666, 3'd5, 1, 1);
        end
        step(1, 1, 0, M_HOLD, 8'h00, 8'h00, Z, Z, 3'd0, 0, 0);
        // fill to 4, then reset together with flush and UP
        step(1, 0, 1, M_UP, 8'h01, 8'hC1, 40'h0000000001, 40'h00000000C1, 3'd1, 0, 0);
        step(1, 0, 1, M_UP, 8'h02, 8'hC2, 40'h0000000102, 40'h000000C1C2, 3'd2, 0, 0);
        step(1, 0, 1, M_UP, 8'h03, 8'hC3, 40'h0000010203, 40'h0000C1C2C3, 3'd3, 0, 0);
        step(1, 0, 1, M_UP, 8'h04, 8'hC4, 40'h0001020304, 40'h00C1C2C3C4, 3'd4, 0, 0);
        step(0, 1, 1, M_UP, 8'h09, 8'h90, Z, Z, 3'd0, 0, 0);
        step(1, 0, 1, M_UP, 8'h5A, 8'hA5, 40'h000000005A, 40'h00000000A5, 3'd1, 0, 0);
        // sticky error cleared by reset
        step(1, 0, 1, 3'd7, 8'h01, 8'h02, 40'h000000005A, 40'h00000000A5, 3'd1, 0, 1);
        step(0, 0, 0, M_HOLD, 8'h00, 8'h00, Z, Z, 3'd0, 0, 0);
        step(1, 0, 0, M_HOLD, 8'h00, 8'h00, Z, Z, 3'd0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
